// File: rtl/chrono_run_control.sv
// chrono_run_control
// Run/stop/lap controller for a four-digit BCD chronometer. It debounces the
// two push-buttons, runs the IDLE/RUNNING/PAUSED/LAP state machine, produces
// the counter's count-enable tick and clear pulse, and chooses live or frozen
// digits for the display path.
//
// Optional feature: define CHRONO_AUTOSTOP_EN to pause automatically when the
// counter shows 9999 at the moment a tick would fire. Start/stop then stays
// locked out until lap/reset clears the counter.
//
// Ports
//   CLK            in   system clock, rising edge
//   RST            in   asynchronous reset, active-low
//   btn_start_stop in   raw start/stop button, active-high, asynchronous
//   btn_lap_reset  in   raw lap/reset button, active-high, asynchronous
//   count_in       in   live counter value {d3,d2,d1,d0}, BCD
//   tick_en        out  one-cycle count-enable pulse
//   counter_clr    out  one-cycle synchronous clear pulse
//   display_out    out  digits for the seven-segment decoders
//   state          out  00 IDLE, 01 RUNNING, 10 PAUSED, 11 LAP
//   running        out  high in RUNNING or LAP
module chrono_run_control #(
   parameter int unsigned PRESCALE        = 1000000,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        btn_start_stop,
   input  logic        btn_lap_reset,
   input  logic [15:0] count_in,
   output logic        tick_en,
   output logic        counter_clr,
   output logic [15:0] display_out,
   output logic [1:0]  state,
   output logic        running
);

   localparam int unsigned PW = $clog2(PRESCALE);
   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
   localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RUN    = 2'b01,
      ST_PAUSED = 2'b10,
      ST_LAP    = 2'b11
   } state_t;

   // Button index 0 = start/stop, 1 = lap/reset
   logic [1:0]    r_meta;
   logic [1:0]    r_sync;
   logic [1:0]    r_level;
   logic [1:0]    r_press;
   logic [DW-1:0] r_cnt [2];

   state_t        r_state;
   state_t        w_next;
   logic          w_clr;
   logic          w_capture;

   logic [PW-1:0] r_presc;
   logic          r_tick;
   logic          r_clr;
   logic          r_run;
   logic [15:0]   r_disp;
   logic [15:0]   r_lap;

   logic          w_go_ss;
   logic          w_go_lr;
   logic          w_running;
   logic          w_wrap;
   logic          w_autostop;
   logic          w_halt;

   // 2-FF synchronizers and debounce filters; press is a registered rising-edge pulse
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_meta   <= '0;
         r_sync   <= '0;
         r_level  <= '0;
         r_press  <= '0;
         r_cnt[0] <= '0;
         r_cnt[1] <= '0;
      end else begin
         r_meta <= {btn_lap_reset, btn_start_stop};
         r_sync <= r_meta;
         for (int i = 0; i < 2; i++) begin
            r_press[i] <= 1'b0;
            if (r_sync[i] == r_level[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == DEB_MAX) begin
               r_cnt[i]   <= '0;
               r_level[i] <= r_sync[i];
               r_press[i] <= r_sync[i];
            end else begin
               r_cnt[i] <= r_cnt[i] + DW'(1);
            end
         end
      end
   end

   // Start/stop wins when both events land in the same cycle
   assign w_go_ss   = r_press[0];
   assign w_go_lr   = r_press[1] & ~r_press[0];
   assign w_running = (r_state == ST_RUN) || (r_state == ST_LAP);
   assign w_wrap    = w_running && (r_presc == PRESC_MAX);

`ifdef CHRONO_AUTOSTOP_EN
   logic r_halt;

   assign w_autostop = w_wrap && (count_in == 16'h9999);
   assign w_halt     = r_halt;

   // Lock out start/stop after an auto-stop until the counter is cleared
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_halt <= 1'b0;
      end else if (w_autostop) begin
         r_halt <= 1'b1;
      end else if (w_clr) begin
         r_halt <= 1'b0;
      end
   end
`else
   assign w_autostop = 1'b0;
   assign w_halt     = 1'b0;
`endif

   // State register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next    = r_state;
      w_clr     = 1'b0;
      w_capture = 1'b0;
      if (w_autostop) begin
         w_next = ST_PAUSED;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_go_ss) w_next = ST_RUN;
            end
            ST_RUN: begin
               if (w_go_ss) begin
                  w_next = ST_PAUSED;
               end else if (w_go_lr) begin
                  w_next    = ST_LAP;
                  w_capture = 1'b1;
               end
            end
            ST_LAP: begin
               if (w_go_ss)      w_next = ST_PAUSED;
               else if (w_go_lr) w_next = ST_RUN;
            end
            ST_PAUSED: begin
               if (w_go_ss) begin
                  if (!w_halt) w_next = ST_RUN;
               end else if (w_go_lr) begin
                  w_next = ST_IDLE;
                  w_clr  = 1'b1;
               end
            end
            default: w_next = ST_IDLE;
         endcase
      end
   end

   // Prescaler, tick/clear pulses, lap capture and display select
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_presc <= '0;
         r_tick  <= 1'b0;
         r_clr   <= 1'b0;
         r_run   <= 1'b0;
         r_disp  <= '0;
         r_lap   <= '0;
      end else begin
         r_clr  <= w_clr;
         r_run  <= (w_next == ST_RUN) || (w_next == ST_LAP);
         r_tick <= w_wrap && !w_autostop && !w_clr;
         if (w_capture) begin
            r_lap <= count_in;
         end
         // On LAP entry count_in is the value being captured, so it is shown directly
         r_disp <= ((w_next == ST_LAP) && (r_state == ST_LAP)) ? r_lap : count_in;
         if (w_next == ST_IDLE) begin
            r_presc <= '0;
         end else if (w_running && !w_autostop) begin
            r_presc <= w_wrap ? '0 : r_presc + PW'(1);
         end
      end
   end

   assign tick_en     = r_tick;
   assign counter_clr = r_clr;
   assign display_out = r_disp;
   assign state       = r_state;
   assign running     = r_run;

endmodule

// File: tb/tb_chrono_run_control.sv
`timescale 1ns/1ps
module tb_chrono_run_control;

   localparam int PRESCALE = 4;
   localparam int DEB      = 3;

   logic        CLK = 1'b0;
   logic        RST;
   logic        bss;
   logic        blr;
   logic [15:0] count_in;
   wire         tick_en;
   wire         counter_clr;
   wire  [15:0] display_out;
   wire  [1:0]  state;
   wire         running;

   int checks;
   int errors;

   chrono_run_control #(
      .PRESCALE        (PRESCALE),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .CLK            (CLK),
      .RST            (RST),
      .btn_start_stop (bss),
      .btn_lap_reset  (blr),
      .count_in       (count_in),
      .tick_en        (tick_en),
      .counter_clr    (counter_clr),
      .display_out    (display_out),
      .state          (state),
      .running        (running)
   );

   always #5 CLK = ~CLK;

   // Reference model (state codes: 0 idle, 1 running, 2 paused, 3 lap)
   int          m_state;
   int          m_presc;
   bit          m_tick;
   bit          m_clr;
   bit          m_run;
   bit          m_halt;
   logic [15:0] m_disp;
   logic [15:0] m_lap;
   bit          h_ss [DEB+2];
   bit          h_lr [DEB+2];
   bit          lvl_ss;
   bit          lvl_lr;
   bit          ev_ss;
   bit          ev_lr;

   // Bench-side BCD counter that reacts to the expected tick/clear
   logic [15:0] bcnt;
   bit          force_en;
   logic [15:0] force_val;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      r = v;
      for (int d = 0; d < 4; d++) begin
         if (r[d*4 +: 4] == 4'd9) begin
            r[d*4 +: 4] = 4'd0;
         end else begin
            r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
            return r;
         end
      end
      return r;
   endfunction

   task automatic model_reset();
      m_state = 0; m_presc = 0; m_tick = 0; m_clr = 0; m_run = 0; m_halt = 0;
      m_disp = '0; m_lap = '0;
      lvl_ss = 0; lvl_lr = 0; ev_ss = 0; ev_lr = 0;
      for (int i = 0; i < DEB + 2; i++) begin
         h_ss[i] = 0;
         h_lr[i] = 0;
      end
   endtask

   task automatic model_step();
      bit go_ss, go_lr, run_now, stop_now, clr_now, tick_now, diff_ss, diff_lr;
      int nxt;
      go_ss    = ev_ss;
      go_lr    = ev_lr && !ev_ss;
      run_now  = (m_state == 1) || (m_state == 3);
      stop_now = 0;
`ifdef CHRONO_AUTOSTOP_EN
      stop_now = run_now && (m_presc == PRESCALE - 1) && (count_in == 16'h9999);
`endif
      nxt = m_state; clr_now = 0; tick_now = 0;
      if (stop_now) begin
         nxt = 2;
         m_halt = 1;
      end else begin
         case (m_state)
            0: if (go_ss) nxt = 1;
            1: if (go_ss) nxt = 2;
               else if (go_lr) begin nxt = 3; m_lap = count_in; end
            3: if (go_ss) nxt = 2;
               else if (go_lr) nxt = 1;
            default: if (go_ss) begin
                        if (!m_halt) nxt = 1;
                     end else if (go_lr) begin
                        nxt = 0; clr_now = 1; m_halt = 0;
                     end
         endcase
      end
      if (nxt == 0) begin
         m_presc = 0;
      end else if (run_now && !stop_now) begin
         m_presc = m_presc + 1;
         if (m_presc == PRESCALE) begin
            m_presc  = 0;
            tick_now = 1;
         end
      end
      m_disp  = (nxt == 3) ? m_lap : count_in;
      m_run   = (nxt == 1) || (nxt == 3);
      m_tick  = tick_now;
      m_clr   = clr_now;
      m_state = nxt;
      // Debounce: raw sample seen two edges late; level flips after DEB differing samples
      for (int i = DEB + 1; i > 0; i--) begin
         h_ss[i] = h_ss[i-1];
         h_lr[i] = h_lr[i-1];
      end
      h_ss[0] = bss;
      h_lr[0] = blr;
      diff_ss = 1; diff_lr = 1;
      for (int i = 2; i < DEB + 2; i++) begin
         if (h_ss[i] == lvl_ss) diff_ss = 0;
         if (h_lr[i] == lvl_lr) diff_lr = 0;
      end
      ev_ss = diff_ss && !lvl_ss;
      ev_lr = diff_lr && !lvl_lr;
      if (diff_ss) lvl_ss = !lvl_ss;
      if (diff_lr) lvl_lr = !lvl_lr;
   endtask

   task automatic cycle();
      bit p_tick, p_clr;
      p_tick = m_tick;
      p_clr  = m_clr;
      @(posedge CLK);
      model_step();
      #1;
      chk("state", 16'(state), 16'(m_state));
      chk("running", 16'(running), 16'(m_run));
      chk("tick_en", 16'(tick_en), 16'(m_tick));
      chk("counter_clr", 16'(counter_clr), 16'(m_clr));
      chk("display_out", display_out, m_disp);
      chk("tick_clr_excl", 16'(tick_en & counter_clr), 16'h0);
      if (p_clr)       bcnt = '0;
      else if (p_tick) bcnt = bcd_inc(bcnt);
      count_in = force_en ? force_val : bcnt;
   endtask

   task automatic idle(input int n);
      repeat (n) cycle();
   endtask

   task automatic wait_state(input logic [1:0] s, output int n);
      n = 0;
      do begin
         cycle();
         n++;
      end while (state !== s && n < 16);
   endtask

   initial begin
      int n, gap, cnt, changes;
      logic [1:0]  prev;
      logic [15:0] c_prev;
      checks = 0; errors = 0;
      RST = 1'b0; bss = 1'b0; blr = 1'b0;
      force_en = 0; force_val = '0; bcnt = '0; count_in = '0;
      model_reset();
      #2;
      chk("rst_state", 16'(state), 16'h0);
      chk("rst_tick", 16'(tick_en), 16'h0);
      chk("rst_clr", 16'(counter_clr), 16'h0);
      chk("rst_running", 16'(running), 16'h0);
      chk("rst_display", display_out, 16'h0000);
      @(negedge CLK);
      RST = 1'b1;
      idle(3);

      // Clean start press: transition six edges after the raw edge
      bss = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         cycle();
         if (i == 5) chk("start_before", 16'(state), 16'h0);
         if (i == 6) chk("start_latency", 16'(state), 16'h1);
      end
      bss = 1'b0;
      idle(8);
      chk("start_running", 16'(running), 16'h1);

      // Lap freeze at 0123 while the counter keeps advancing
      force_en = 1; force_val = 16'h0123; count_in = 16'h0123;
      blr = 1'b1;
      wait_state(2'b11, n);
      chk("lap_enter", 16'(state), 16'h3);
      force_en = 0; bcnt = 16'h0123; blr = 1'b0;
      idle(10);
      chk("lap_frozen", display_out, 16'h0123);
      blr = 1'b1;
      wait_state(2'b01, n);
      blr = 1'b0;
      idle(6);
      c_prev = count_in;
      cycle();
      chk("live_after_lap", display_out, c_prev);

      // Pause with prescaler at 2, resume gives a 2-cycle first tick
      n = 0;
      while (!(m_presc == 0 && m_state == 1) && n < 20) begin
         cycle();
         n++;
      end
      bss = 1'b1;
      repeat (8) cycle();
      bss = 1'b0;
      chk("paused", 16'(state), 16'h2);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         if (tick_en === 1'b1) cnt++;
      end
      chk("paused_no_tick", 16'(cnt), 16'h0);
      bss = 1'b1;
      wait_state(2'b01, n);
      gap = 0;
      do begin
         cycle();
         gap++;
      end while (tick_en !== 1'b1 && gap < 8);
      chk("resume_gap", 16'(gap), 16'h2);
      repeat (4) cycle();
      bss = 1'b0;
      idle(8);
      bss = 1'b1;
      repeat (8) cycle();
      bss = 1'b0;
      idle(6);
      chk("paused_again", 16'(state), 16'h2);
      blr = 1'b1;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         cycle();
         if (counter_clr === 1'b1) cnt++;
      end
      blr = 1'b0;
      chk("clr_once", 16'(cnt), 16'h1);
      chk("cleared_idle", 16'(state), 16'h0);
      idle(6);

      // Bouncing start press: 1,0 then stable high
      changes = 0; prev = state;
      for (int i = 0; i < 22; i++) begin
         bss = (i == 0) || (i >= 2 && i < 12);
         cycle();
         if (state !== prev) changes++;
         prev = state;
      end
      bss = 1'b0;
      chk("bounce_changes", 16'(changes), 16'h1);
      chk("bounce_state", 16'(state), 16'h1);
      idle(6);

      // Simultaneous presses while running: start/stop wins
      bss = 1'b1; blr = 1'b1;
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         if (i == 9) begin bss = 1'b0; blr = 1'b0; end
         cycle();
         if (counter_clr === 1'b1) cnt++;
      end
      chk("simul_state", 16'(state), 16'h2);
      chk("simul_no_clr", 16'(cnt), 16'h0);

      // Counter at 9999 while running
      bss = 1'b1;
      wait_state(2'b01, n);
      bss = 1'b0;
      idle(6);
      force_en = 1; force_val = 16'h9999; count_in = 16'h9999;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         if (tick_en === 1'b1) cnt++;
      end
`ifdef CHRONO_AUTOSTOP_EN
      chk("autostop_ticks", 16'(cnt), 16'h0);
      chk("autostop_state", 16'(state), 16'h2);
`else
      chk("wrap_ticks", 16'(cnt), 16'h2);
`endif
      bss = 1'b1;
      repeat (8) cycle();
      bss = 1'b0;
      idle(6);
      chk("9999_after_ss", 16'(state), 16'h2);
      blr = 1'b1;
      repeat (8) cycle();
      blr = 1'b0;
      idle(4);
      chk("9999_cleared", 16'(state), 16'h0);
      force_en = 0; bcnt = '0;

      // Reset mid-run with start/stop held through release
      bss = 1'b1;
      wait_state(2'b01, n);
      bss = 1'b0;
      idle(10);
      bss = 1'b1;
      RST = 1'b0;
      #1;
      model_reset();
      chk("midrst_state", 16'(state), 16'h0);
      chk("midrst_running", 16'(running), 16'h0);
      chk("midrst_tick", 16'(tick_en), 16'h0);
      chk("midrst_display", display_out, 16'h0000);
      @(negedge CLK);
      RST = 1'b1;
      wait_state(2'b01, n);
      chk("reaccept_latency", 16'(n), 16'h6);
      bss = 1'b0;
      idle(8);

      // Randomized button activity against the model
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(11) == 0) bss = ~bss;
         if ($urandom_range(13) == 0) blr = ~blr;
         if ($urandom_range(299) == 0) bcnt = 16'h9997;
         cycle();
      end
      bss = 1'b0; blr = 1'b0;
      idle(10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
